// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator: one command in, one bus cycle out,
// then a one-cycle response pulse carrying read data or a timeout error.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_dat,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  assign cmd_ready = (state == IDLE) & ~reset;
  assign wbm_stb_o = wbm_cyc_o;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_cyc_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          // ack takes priority over a timeout landing on the same edge
          if (wbm_ack_i || cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ~wbm_ack_i;
            rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_dat   <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
